// File: rtl/note_sprite_overlay.sv
// Note sprite overlay: draws a row of note sprites from a shared ROM
// over the background, with per-note after-glow, colour key and dim mode.
module note_sprite_overlay #(
  parameter int          NOTE_CNT    = 7,
  parameter int          SPR_W       = 32,
  parameter int          SPR_H       = 32,
  parameter int          X0          = 112,
  parameter int          X_PITCH     = 64,
  parameter int          Y0          = 224,
  parameter int          HOLD_FRAMES = 15,
  parameter int          ROM_LAT     = 1,
  parameter logic [23:0] KEY_COLOR   = 24'hFF00FF,
  parameter int          AW          = $clog2(NOTE_CNT*SPR_W*SPR_H)
) (
  input  logic                vga_clk,
  input  logic                rst,
  input  logic [9:0]          pos_x,
  input  logic [9:0]          pos_y,
  input  logic [23:0]         bg_data,
  input  logic                frame_start,
  input  logic [NOTE_CNT-1:0] note,
  input  logic                show_all,
  output logic [AW-1:0]       rom_addr,
  input  logic [23:0]         rom_data,
  output logic [23:0]         pos_data
);

  localparam int ROW_W  = NOTE_CNT * X_PITCH;
  localparam int SPR_SZ = SPR_W * SPR_H;

  logic [7:0]          hc [NOTE_CNT];
  logic [NOTE_CNT-1:0] lit;

  always_ff @(posedge vga_clk) begin
    for (int i = 0; i < NOTE_CNT; i++) begin
      if (rst)
        hc[i] <= 8'd0;
      else if (note[i])
        hc[i] <= 8'(HOLD_FRAMES);
      else if (frame_start && hc[i] != 8'd0)
        hc[i] <= hc[i] - 8'd1;
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < NOTE_CNT; i++)
      lit[i] = note[i] | (hc[i] != 8'd0);
  end

  // Left/above the row wraps to a large offset and simply misses.
  logic [9:0]    dx, dy, idx, off;
  logic [31:0]   dx32, dy32, idx32, off32;
  logic          hit, lit_sel, draw, dim;
  logic [AW-1:0] addr_nx;

  assign dx    = pos_x - 10'(X0);
  assign dy    = pos_y - 10'(Y0);
  assign idx   = dx / 10'(X_PITCH);
  assign off   = dx % 10'(X_PITCH);
  assign dx32  = 32'(dx);
  assign dy32  = 32'(dy);
  assign idx32 = 32'(idx);
  assign off32 = 32'(off);

  always_comb begin
    hit = (dy32 < 32'(SPR_H))
       && (dx32 < 32'(ROW_W))
       && (off32 < 32'(SPR_W));
    lit_sel = 1'b0;
    for (int i = 0; i < NOTE_CNT; i++)
      if (idx32 == 32'(i)) lit_sel = lit[i];
    draw = hit & (lit_sel | show_all);
    dim  = hit & ~lit_sel;
    addr_nx = AW'(idx32 * 32'(SPR_SZ)
                + dy32 * 32'(SPR_W)
                + off32);
  end

  // Slot 0 lines up with rom_addr, slot ROM_LAT with rom_data.
  logic        draw_d [ROM_LAT+1];
  logic        dim_d  [ROM_LAT+1];
  logic [23:0] bg_d   [ROM_LAT+1];

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      rom_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        draw_d[i] <= 1'b0;
        dim_d[i]  <= 1'b0;
        bg_d[i]   <= 24'h0;
      end
    end else begin
      rom_addr  <= draw ? addr_nx : '0;
      draw_d[0] <= draw;
      dim_d[0]  <= dim;
      bg_d[0]   <= bg_data;
      for (int i = 1; i <= ROM_LAT; i++) begin
        draw_d[i] <= draw_d[i-1];
        dim_d[i]  <= dim_d[i-1];
        bg_d[i]   <= bg_d[i-1];
      end
    end
  end

  logic [23:0] half;
  assign half = {1'b0, rom_data[23:17],
                 1'b0, rom_data[15:9],
                 1'b0, rom_data[7:1]};

  always_ff @(posedge vga_clk) begin
    if (rst)
      pos_data <= 24'h0;
    else if (!draw_d[ROM_LAT] || rom_data == KEY_COLOR)
      pos_data <= bg_d[ROM_LAT];
    else if (dim_d[ROM_LAT])
      pos_data <= half;
    else
      pos_data <= rom_data;
  end

endmodule
